// File: rtl/lsu_mem_if.sv
// LSU-to-memory bus: registered request/write signals from the LSU, single-cycle ack with read data from memory.
// The master drives the request and write signals; the slave returns bus_ack and bus_rdata.
interface lsu_mem_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     bus_req;
  logic                     bus_we;
  logic [ADDRESS_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0]    bus_wdata;
  logic [DATA_WIDTH/8-1:0]  bus_wstrb;
  logic                     bus_ack;
  logic [DATA_WIDTH-1:0]    bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_mem.sv
// MEM-stage load/store unit: IDLE->REQ->DONE bus FSM, >=3-cycle latency, stall_m held until DONE.
// Define LSU_TIMEOUT_EN to add a 255-cycle REQ watchdog and the bus_err_m pulse.
module lsu_mem #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_write_m,
  input  logic [1:0]               result_src_m,
  input  logic [2:0]               funct3_m,
  input  logic [ADDRESS_WIDTH-1:0] alu_result_m,
  input  logic [DATA_WIDTH-1:0]    write_data_m,
  output logic                     stall_m,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic                     misaligned_m,
`ifdef LSU_TIMEOUT_EN
  output logic                     bus_err_m,
`endif
  lsu_mem_if.master                bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                     r_bus_req;
  logic                     r_bus_we;
  logic [ADDRESS_WIDTH-1:0] r_bus_addr;
  logic [DATA_WIDTH-1:0]    r_bus_wdata;
  logic [3:0]               r_bus_wstrb;
  logic                     r_load;
  logic [2:0]               r_f3;
  logic [1:0]               r_lane;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [2:0]               r_ld_f3;
  logic [1:0]               r_ld_lane;

  logic                     w_is_load;
  logic                     w_access;
  logic                     w_word;
  logic                     w_half;
  logic                     w_misalign;
  logic                     w_go;
  logic                     w_bad;
  logic                     w_ack;
  logic                     w_timeout;
  logic [3:0]               w_wstrb;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic [7:0]               w_byte;
  logic [15:0]              w_half_dat;
  logic [DATA_WIDTH-1:0]    w_ext;

`ifdef LSU_TIMEOUT_EN
  logic [7:0]               r_tmo_cnt;
  logic                     r_bus_err;
  assign w_timeout = (r_state == S_REQ) && !bus.bus_ack && (r_tmo_cnt == 8'hFF);
  assign bus_err_m = r_bus_err;
`else
  assign w_timeout = 1'b0;
`endif

  // funct3[1] selects word (covers 011/110/111 too); funct3[2] only marks unsigned loads
  assign w_is_load  = (result_src_m == 2'b01);
  assign w_access   = mem_write_m | w_is_load;
  assign w_word     = funct3_m[1];
  assign w_half     = ~funct3_m[1] & funct3_m[0];
  assign w_misalign = (w_half & alu_result_m[0]) | (w_word & (alu_result_m[1:0] != 2'b00));
  assign w_go       = w_access & ~w_misalign;
  assign w_bad      = (r_state == S_IDLE) & w_access & w_misalign;
  assign w_ack      = (r_state == S_REQ) & bus.bus_ack;

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = write_data_m;
    if (w_half) begin
      w_wstrb = 4'b0011 << {alu_result_m[1], 1'b0};
      w_wdata = {2{write_data_m[15:0]}};
    end else if (!w_word) begin
      w_wstrb = 4'b0001 << alu_result_m[1:0];
      w_wdata = {4{write_data_m[7:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_m     = 1'b0;
    misaligned_m = 1'b0;
    case (r_state)
      S_IDLE: if (w_go) w_state_nxt = S_REQ;
      S_REQ:  if (bus.bus_ack || w_timeout) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst_n) begin
      stall_m      = w_go && (r_state != S_DONE);
      misaligned_m = w_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= 4'b0000;
      r_load      <= 1'b0;
      r_f3        <= 3'b000;
      r_lane      <= 2'b00;
      r_rdata     <= '0;
      r_ld_f3     <= 3'b000;
      r_ld_lane   <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      r_tmo_cnt   <= 8'h00;
      r_bus_err   <= 1'b0;
`endif
    end else begin
`ifdef LSU_TIMEOUT_EN
      r_bus_err <= 1'b0;
`endif
      if ((r_state == S_IDLE) && w_go) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= mem_write_m;
        r_bus_addr  <= {alu_result_m[ADDRESS_WIDTH-1:2], 2'b00};
        r_bus_wdata <= w_wdata;
        r_bus_wstrb <= mem_write_m ? w_wstrb : 4'b0000;
        r_load      <= ~mem_write_m;
        r_f3        <= funct3_m;
        r_lane      <= alu_result_m[1:0];
`ifdef LSU_TIMEOUT_EN
        r_tmo_cnt   <= 8'h00;
`endif
      end else if (w_bad && !mem_write_m) begin
        r_rdata <= '0;
      end else if (w_ack) begin
        r_bus_req   <= 1'b0;
        r_bus_we    <= 1'b0;
        r_bus_wstrb <= 4'b0000;
        if (r_load) begin
          r_rdata   <= bus.bus_rdata;
          r_ld_f3   <= r_f3;
          r_ld_lane <= r_lane;
        end
      end else if (w_timeout) begin
        r_bus_req   <= 1'b0;
        r_bus_we    <= 1'b0;
        r_bus_wstrb <= 4'b0000;
        if (r_load) r_rdata <= '0;
`ifdef LSU_TIMEOUT_EN
        r_bus_err   <= 1'b1;
`endif
      end
`ifdef LSU_TIMEOUT_EN
      if ((r_state == S_REQ) && !bus.bus_ack && !w_timeout) r_tmo_cnt <= r_tmo_cnt + 8'd1;
`endif
    end
  end

  // lane select and extension act on the raw captured word so the result holds until the next capture
  assign w_byte     = r_rdata[{r_ld_lane, 3'b000} +: 8];
  assign w_half_dat = r_rdata[{r_ld_lane[1], 4'b0000} +: 16];

  always_comb begin
    case (r_ld_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half_dat[15]}}, w_half_dat};
      3'b100:  w_ext = {24'h000000, w_byte};
      3'b101:  w_ext = {16'h0000, w_half_dat};
      default: w_ext = r_rdata;
    endcase
  end

  assign read_data_m   = (w_bad && !mem_write_m) ? '0 : w_ext;

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.bus_wstrb = r_bus_wstrb;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: loads, stores, misalignment, stray acks and mid-transaction reset.
module tb_lsu_mem;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m;
  logic [31:0] write_data_m;
  logic        stall_m;
  logic [31:0] read_data_m;
  logic        misaligned_m;
`ifdef LSU_TIMEOUT_EN
  logic        bus_err_m;
`endif

  int total = 0;
  int bad   = 0;

  lsu_mem_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  lsu_mem #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_write_m  (mem_write_m),
    .result_src_m (result_src_m),
    .funct3_m     (funct3_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .stall_m      (stall_m),
    .read_data_m  (read_data_m),
    .misaligned_m (misaligned_m),
`ifdef LSU_TIMEOUT_EN
    .bus_err_m    (bus_err_m),
`endif
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle;
    mem_write_m  = 1'b0;
    result_src_m = 2'b00;
    funct3_m     = 3'b000;
    alu_result_m = 32'h0;
    write_data_m = 32'h0;
  endtask

  // one aligned access; ack arrives on REQ cycle ack_at, results sampled during DONE
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                        output int n_stall, output logic [31:0] o_addr, output logic [31:0] o_wdata,
                        output logic [3:0] o_strb, output logic o_we, output logic o_stable,
                        output logic [31:0] o_rdm, output logic o_done_req);
    mem_write_m  = we;
    result_src_m = we ? 2'b00 : 2'b01;
    funct3_m     = f3;
    alu_result_m = addr;
    write_data_m = wd;
    n_stall  = 0;
    o_stable = 1'b1;
    #1;
    if (stall_m) n_stall++;
    cyc;
    o_addr  = bus_if.bus_addr;
    o_wdata = bus_if.bus_wdata;
    o_strb  = bus_if.bus_wstrb;
    o_we    = bus_if.bus_we;
    for (int k = 1; k <= ack_at; k++) begin
      if (stall_m) n_stall++;
      if (!bus_if.bus_req || bus_if.bus_addr !== o_addr || bus_if.bus_wdata !== o_wdata ||
          bus_if.bus_wstrb !== o_strb || bus_if.bus_we !== o_we) o_stable = 1'b0;
      if (k == ack_at) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rd;
      end
      cyc;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = 32'h0;
    end
    #1;
    if (stall_m) n_stall++;
    o_rdm      = read_data_m;
    o_done_req = bus_if.bus_req;
    go_idle();
    cyc;
  endtask

  int          ns;
  logic [31:0] a, wdat, rdm;
  logic [3:0]  st;
  logic        we_o, stable, dreq;

  initial begin
    rst_n = 1'b0;
    go_idle();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    cyc; cyc;
    check("rst_stall", {31'h0, stall_m}, 32'h0);
    check("rst_misal", {31'h0, misaligned_m}, 32'h0);
    check("rst_req",   {31'h0, bus_if.bus_req}, 32'h0);
    check("rst_we",    {31'h0, bus_if.bus_we}, 32'h0);
    check("rst_strb",  {28'h0, bus_if.bus_wstrb}, 32'h0);
    check("rst_addr",  bus_if.bus_addr, 32'h0);
    check("rst_wdata", bus_if.bus_wdata, 32'h0);
    check("rst_rdata", read_data_m, 32'h0);
    rst_n = 1'b1;
    cyc;

    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, ns, a, wdat, st, we_o, stable, rdm, dreq);
    check("lw_stall_cycles", ns, 3);
    check("lw_addr",   a, 32'h100);
    check("lw_we",     {31'h0, we_o}, 32'h0);
    check("lw_stable", {31'h0, stable}, 32'h1);
    check("lw_data",   rdm, 32'hDEADBEEF);
    check("lw_done_req", {31'h0, dreq}, 32'h0);
    #1;
    check("lw_hold",   read_data_m, 32'hDEADBEEF);

    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1, ns, a, wdat, st, we_o, stable, rdm, dreq);
    check("lb_data",  rdm, 32'hFFFFFF80);
    check("lb_addr",  a, 32'h100);
    check("lb_stall_cycles", ns, 2);
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1, ns, a, wdat, st, we_o, stable, rdm, dreq);
    check("lbu_data", rdm, 32'h00000080);
    access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80123456, 1, ns, a, wdat, st, we_o, stable, rdm, dreq);
    check("lh_data",  rdm, 32'hFFFF8012);
    access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80123456, 1, ns, a, wdat, st, we_o, stable, rdm, dreq);
    check("lhu_data", rdm, 32'h00008012);
    access(1'b0, 3'b000, 32'h101, 32'h0, 32'h80123456, 1, ns, a, wdat, st, we_o, stable, rdm, dreq);
    check("lb1_data", rdm, 32'h00000034);
    access(1'b0, 3'b011, 32'h108, 32'h0, 32'hCAFEF00D, 1, ns, a, wdat, st, we_o, stable, rdm, dreq);
    check("f3_011_data", rdm, 32'hCAFEF00D);
    check("f3_011_addr", a, 32'h108);

    access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 3, ns, a, wdat, st, we_o, stable, rdm, dreq);
    check("sh_we",     {31'h0, we_o}, 32'h1);
    check("sh_strb",   {28'h0, st}, 32'hC);
    check("sh_wdata",  wdat, 32'hABCDABCD);
    check("sh_addr",   a, 32'h100);
    check("sh_stable", {31'h0, stable}, 32'h1);
    check("sh_stall_cycles", ns, 4);
    access(1'b1, 3'b000, 32'h101, 32'h000000EF, 32'h0, 1, ns, a, wdat, st, we_o, stable, rdm, dreq);
    check("sb_strb",  {28'h0, st}, 32'h2);
    check("sb_wdata", wdat, 32'hEFEFEFEF);
    access(1'b1, 3'b010, 32'h104, 32'h11223344, 32'h0, 1, ns, a, wdat, st, we_o, stable, rdm, dreq);
    check("sw_strb",  {28'h0, st}, 32'hF);
    check("sw_wdata", wdat, 32'h11223344);
    check("sw_addr",  a, 32'h104);
    #1;
    check("store_keeps_rdata", read_data_m, 32'hCAFEF00D);

    // misaligned LW returns 0 even though the previous load left a nonzero result
    mem_write_m = 1'b0; result_src_m = 2'b01; funct3_m = 3'b010; alu_result_m = 32'h101;
    #1;
    check("mis_lw_pulse", {31'h0, misaligned_m}, 32'h1);
    check("mis_lw_stall", {31'h0, stall_m}, 32'h0);
    check("mis_lw_data",  read_data_m, 32'h0);
    cyc;
    check("mis_lw_noreq", {31'h0, bus_if.bus_req}, 32'h0);
    go_idle();
    #1;
    check("mis_lw_end",   {31'h0, misaligned_m}, 32'h0);

    mem_write_m = 1'b1; funct3_m = 3'b001; alu_result_m = 32'h103; write_data_m = 32'h1234;
    #1;
    check("mis_sh_pulse", {31'h0, misaligned_m}, 32'h1);
    check("mis_sh_stall", {31'h0, stall_m}, 32'h0);
    cyc;
    check("mis_sh_noreq", {31'h0, bus_if.bus_req}, 32'h0);
    go_idle();

    // stray ack in IDLE must not be captured
    access(1'b0, 3'b010, 32'h10C, 32'h0, 32'h0BADF00D, 1, ns, a, wdat, st, we_o, stable, rdm, dreq);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h55555555;
    cyc;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    #1;
    check("stray_ack_ignored", read_data_m, 32'h0BADF00D);
    check("stray_ack_noreq", {31'h0, bus_if.bus_req}, 32'h0);

    // reset while in REQ, then a late ack
    mem_write_m = 1'b0; result_src_m = 2'b01; funct3_m = 3'b010; alu_result_m = 32'h200;
    cyc;
    check("mid_rst_req_up", {31'h0, bus_if.bus_req}, 32'h1);
    rst_n = 1'b0;
    go_idle();
    cyc;
    rst_n = 1'b1;
    check("mid_rst_req_down", {31'h0, bus_if.bus_req}, 32'h0);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h12345678;
    cyc;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    #1;
    check("late_ack_no_capture", read_data_m, 32'h0);
    check("late_ack_noreq", {31'h0, bus_if.bus_req}, 32'h0);
    check("late_ack_nostall", {31'h0, stall_m}, 32'h0);

`ifdef LSU_TIMEOUT_EN
    begin
      logic seen;
      logic [31:0] tdat;
      seen = 1'b0;
      tdat = 32'hFFFFFFFF;
      access(1'b0, 3'b010, 32'h110, 32'h0, 32'h77777777, 1, ns, a, wdat, st, we_o, stable, rdm, dreq);
      mem_write_m = 1'b0; result_src_m = 2'b01; funct3_m = 3'b010; alu_result_m = 32'h300;
      for (int c = 0; c < 300 && !seen; c++) begin
        cyc;
        if (bus_err_m) begin
          seen = 1'b1;
          tdat = read_data_m;
        end
      end
      check("tmo_err_pulse", {31'h0, seen}, 32'h1);
      check("tmo_data_zero", tdat, 32'h0);
      go_idle();
      cyc;
      check("tmo_err_one_cycle", {31'h0, bus_err_m}, 32'h0);
      check("tmo_back_idle_req", {31'h0, bus_if.bus_req}, 32'h0);
      check("tmo_back_idle_stall", {31'h0, stall_m}, 32'h0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
